// File: rtl/ccd_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ccd_phase_sequencer
//  Purpose  : Programmable CCD clock sequencer. Generates the transfer pulse
//             (phi_p), the horizontal shift phases (phi_l1/phi_l2), the reset
//             clock (phi_r) and a per-pixel ADC start strobe. It runs either
//             continuously or for a programmed burst of frames.
//  Ports    : i_clk, i_rst_n      - clock and synchronous active-low reset
//             i_enable, i_start   - run enable (level) and start pulse
//             i_cfg_load, i_cfg_* - shadow configuration capture
//             o_phi_p/l1/l2/r     - CCD pad clocks
//             o_adc_start         - one-cycle ADC trigger per pixel
//             o_pixel_idx         - current pixel during SHIFT, else 0
//             o_frame_done        - pulse in the last SHIFT cycle
//             o_busy              - high when not IDLE
//             o_cfg_pending       - shadow config not yet applied
//  Revision : 1.0 - initial release
// ============================================================================
module ccd_phase_sequencer #(
    parameter int CYCLES_PER_PIXEL = 8,
    parameter int ADC_PHASE        = 6,
    parameter int PIX_W            = 12,
    parameter int HOLD_W           = 24,
    parameter int FRAME_W          = 8,
    parameter int PW_W             = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic               i_start,
    input  logic               i_cfg_load,
    input  logic [PIX_W-1:0]   i_cfg_pixels,
    input  logic [PW_W-1:0]    i_cfg_pulse_w,
    input  logic [HOLD_W-1:0]  i_cfg_hold,
    input  logic [FRAME_W-1:0] i_cfg_frames,
    output logic               o_phi_p,
    output logic               o_phi_l1,
    output logic               o_phi_l2,
    output logic               o_phi_r,
    output logic               o_adc_start,
    output logic [PIX_W-1:0]   o_pixel_idx,
    output logic               o_frame_done,
    output logic               o_busy,
    output logic               o_cfg_pending
);

    localparam int c_cyc_w = $clog2(CYCLES_PER_PIXEL);
    // One counter serves both the PULSE width and the HOLD time.
    localparam int c_cnt_w = (HOLD_W > PW_W) ? HOLD_W : PW_W;

    localparam logic [c_cyc_w-1:0] c_cyc_last = c_cyc_w'(CYCLES_PER_PIXEL - 1);
    localparam logic [c_cyc_w-1:0] c_cyc_half = c_cyc_w'(CYCLES_PER_PIXEL / 2);
    localparam logic [c_cyc_w-1:0] c_cyc_3q   = c_cyc_w'((3 * CYCLES_PER_PIXEL) / 4);
    localparam logic [c_cyc_w-1:0] c_adc_cyc  = c_cyc_w'(ADC_PHASE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cyc_w-1:0]   r_cyc;
    logic [PIX_W-1:0]     r_pix;
    logic [FRAME_W-1:0]   r_frames_done;

    logic [PIX_W-1:0]     r_sh_pixels, r_act_pixels;
    logic [PW_W-1:0]      r_sh_pulse_w, r_act_pulse_w;
    logic [HOLD_W-1:0]    r_sh_hold, r_act_hold;
    logic [FRAME_W-1:0]   r_sh_frames, r_act_frames;
    logic                 r_pending;

    logic                 r_phi_p, r_phi_l1, r_phi_l2, r_phi_r;
    logic                 r_adc_start, r_frame_done, r_busy;
    logic [PIX_W-1:0]     r_pixel_idx;

    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [c_cyc_w-1:0]   w_cyc_nxt;
    logic [PIX_W-1:0]     w_pix_nxt;
    logic [FRAME_W-1:0]   w_done_nxt;
    logic                 w_apply;

    logic [c_cnt_w-1:0]   w_pw_last;
    logic [c_cnt_w-1:0]   w_hold_last;
    logic [PIX_W-1:0]     w_pix_last;
    logic [FRAME_W-1:0]   w_done_inc;

    logic                 w_phi_p, w_phi_l1, w_phi_l2, w_phi_r;
    logic                 w_adc_start, w_frame_done, w_busy;
    logic [PIX_W-1:0]     w_pixel_idx;

    // Zero pulse width / pixel count behave as one.
    assign w_pw_last   = (r_act_pulse_w == '0) ? '0 : c_cnt_w'(r_act_pulse_w - PW_W'(1));
    assign w_pix_last  = (r_act_pixels == '0)  ? '0 : (r_act_pixels - PIX_W'(1));
    assign w_hold_last = c_cnt_w'(r_act_hold) - c_cnt_w'(1);
    // Completed-frame count saturates so continuous runs never wrap.
    assign w_done_inc  = (&r_frames_done) ? r_frames_done : (r_frames_done + FRAME_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cyc_nxt   = r_cyc;
        w_pix_nxt   = r_pix;
        w_done_nxt  = r_frames_done;
        w_apply     = 1'b0;

        if (!i_enable) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_cyc_nxt   = '0;
            w_pix_nxt   = '0;
            w_done_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        w_state_nxt = ST_PULSE;
                        w_cnt_nxt   = '0;
                        w_done_nxt  = '0;
                        w_apply     = 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (r_cnt == w_pw_last) begin
                        w_state_nxt = ST_SHIFT;
                        w_cnt_nxt   = '0;
                        w_cyc_nxt   = '0;
                        w_pix_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    end
                end
                ST_SHIFT: begin
                    // Power-of-two pixel period: the cycle counter wraps by itself.
                    w_cyc_nxt = r_cyc + c_cyc_w'(1);
                    if (r_cyc == c_cyc_last) begin
                        if (r_pix == w_pix_last) begin
                            w_done_nxt = w_done_inc;
                            w_pix_nxt  = '0;
                            w_cyc_nxt  = '0;
                            w_cnt_nxt  = '0;
                            if ((r_act_frames != '0) && (w_done_inc == r_act_frames)) begin
                                w_state_nxt = ST_IDLE;
                            end else if (r_act_hold == '0) begin
                                w_state_nxt = ST_PULSE;
                                w_apply     = 1'b1;
                            end else begin
                                w_state_nxt = ST_HOLD;
                            end
                        end else begin
                            w_pix_nxt = r_pix + PIX_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == w_hold_last) begin
                        w_state_nxt = ST_PULSE;
                        w_cnt_nxt   = '0;
                        w_apply     = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        // Outputs are registered from the next state so that each cycle's
        // outputs match the state entered at the preceding edge. Active
        // config only changes on PULSE entry, so it is stable whenever the
        // next state is SHIFT.
        w_phi_p      = (w_state_nxt == ST_PULSE);
        w_phi_l1     = (w_state_nxt == ST_SHIFT) && (w_cyc_nxt < c_cyc_half);
        w_phi_l2     = w_phi_p || ((w_state_nxt == ST_SHIFT) && (w_cyc_nxt >= c_cyc_half));
        w_phi_r      = w_phi_p || ((w_state_nxt == ST_SHIFT) && (w_cyc_nxt >= c_cyc_half)
                                   && (w_cyc_nxt < c_cyc_3q));
        w_adc_start  = (w_state_nxt == ST_SHIFT) && (w_cyc_nxt == c_adc_cyc);
        w_pixel_idx  = (w_state_nxt == ST_SHIFT) ? w_pix_nxt : '0;
        w_frame_done = (w_state_nxt == ST_SHIFT) && (w_cyc_nxt == c_cyc_last)
                       && (w_pix_nxt == w_pix_last);
        w_busy       = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_cyc         <= '0;
            r_pix         <= '0;
            r_frames_done <= '0;
            r_phi_p       <= 1'b0;
            r_phi_l1      <= 1'b0;
            r_phi_l2      <= 1'b0;
            r_phi_r       <= 1'b0;
            r_adc_start   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_busy        <= 1'b0;
            r_pixel_idx   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_cyc         <= w_cyc_nxt;
            r_pix         <= w_pix_nxt;
            r_frames_done <= w_done_nxt;
            r_phi_p       <= w_phi_p;
            r_phi_l1      <= w_phi_l1;
            r_phi_l2      <= w_phi_l2;
            r_phi_r       <= w_phi_r;
            r_adc_start   <= w_adc_start;
            r_frame_done  <= w_frame_done;
            r_busy        <= w_busy;
            r_pixel_idx   <= w_pixel_idx;
        end
    end

    // Shadow/active config. The active copy takes the old shadow on PULSE
    // entry; a load in that same cycle lands in the shadow and stays pending.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sh_pixels   <= '0;
            r_sh_pulse_w  <= '0;
            r_sh_hold     <= '0;
            r_sh_frames   <= '0;
            r_act_pixels  <= '0;
            r_act_pulse_w <= '0;
            r_act_hold    <= '0;
            r_act_frames  <= '0;
            r_pending     <= 1'b0;
        end else begin
            if (w_apply) begin
                r_act_pixels  <= r_sh_pixels;
                r_act_pulse_w <= r_sh_pulse_w;
                r_act_hold    <= r_sh_hold;
                r_act_frames  <= r_sh_frames;
            end
            if (i_cfg_load) begin
                r_sh_pixels  <= i_cfg_pixels;
                r_sh_pulse_w <= i_cfg_pulse_w;
                r_sh_hold    <= i_cfg_hold;
                r_sh_frames  <= i_cfg_frames;
                r_pending    <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_phi_p       = r_phi_p;
    assign o_phi_l1      = r_phi_l1;
    assign o_phi_l2      = r_phi_l2;
    assign o_phi_r       = r_phi_r;
    assign o_adc_start   = r_adc_start;
    assign o_pixel_idx   = r_pixel_idx;
    assign o_frame_done  = r_frame_done;
    assign o_busy        = r_busy;
    assign o_cfg_pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_ccd_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ccd_phase_sequencer
//  Purpose  : Self-checking bench for ccd_phase_sequencer. A frame-offset
//             reference model predicts every output each cycle; directed
//             scenarios add aggregate checks on pulse counts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ccd_phase_sequencer;

    localparam int CPP     = 8;
    localparam int ADC_PH  = 6;
    localparam int PIX_W   = 12;
    localparam int HOLD_W  = 24;
    localparam int FRAME_W = 8;
    localparam int PW_W    = 4;
    localparam int c_done_max = (1 << FRAME_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n, enable, start, cfg_load;
    logic [PIX_W-1:0]   cfg_pixels;
    logic [PW_W-1:0]    cfg_pulse_w;
    logic [HOLD_W-1:0]  cfg_hold;
    logic [FRAME_W-1:0] cfg_frames;
    logic               phi_p, phi_l1, phi_l2, phi_r, adc_start, frame_done, busy, cfg_pending;
    logic [PIX_W-1:0]   pixel_idx;

    always #5 clk = ~clk;

    ccd_phase_sequencer #(
        .CYCLES_PER_PIXEL(CPP), .ADC_PHASE(ADC_PH), .PIX_W(PIX_W),
        .HOLD_W(HOLD_W), .FRAME_W(FRAME_W), .PW_W(PW_W)
    ) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_start(start),
        .i_cfg_load(cfg_load), .i_cfg_pixels(cfg_pixels), .i_cfg_pulse_w(cfg_pulse_w),
        .i_cfg_hold(cfg_hold), .i_cfg_frames(cfg_frames),
        .o_phi_p(phi_p), .o_phi_l1(phi_l1), .o_phi_l2(phi_l2), .o_phi_r(phi_r),
        .o_adc_start(adc_start), .o_pixel_idx(pixel_idx), .o_frame_done(frame_done),
        .o_busy(busy), .o_cfg_pending(cfg_pending)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a run is described by the offset of the current cycle
    // from the start of the current frame (PULSE, then SHIFT, then HOLD).
    bit m_run, m_pend;
    int m_off, m_done;
    int sh_pix, sh_pw, sh_hold, sh_fr;
    int act_pix, act_pw, act_hold, act_fr;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_edge();
        bit apply;
        int plen;
        apply = 1'b0;
        if (!rst_n) begin
            m_run = 0; m_off = 0; m_done = 0; m_pend = 0;
            sh_pix = 0; sh_pw = 0; sh_hold = 0; sh_fr = 0;
            act_pix = 0; act_pw = 0; act_hold = 0; act_fr = 0;
            return;
        end
        if (!enable) begin
            m_run = 0; m_done = 0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_off = 0; m_done = 0; apply = 1'b1;
            end
        end else begin
            plen = eff(act_pw) + eff(act_pix) * CPP;
            if (m_off == plen - 1) begin
                if (m_done < c_done_max) m_done++;
                if (act_fr != 0 && m_done == act_fr) m_run = 0;
                else if (act_hold == 0) begin m_off = 0; apply = 1'b1; end
                else m_off = plen;
            end else if (m_off == plen + act_hold - 1) begin
                m_off = 0; apply = 1'b1;
            end else begin
                m_off++;
            end
        end
        if (apply) begin
            act_pix = sh_pix; act_pw = sh_pw; act_hold = sh_hold; act_fr = sh_fr;
        end
        if (cfg_load) begin
            sh_pix = int'(cfg_pixels); sh_pw = int'(cfg_pulse_w);
            sh_hold = int'(cfg_hold); sh_fr = int'(cfg_frames);
            m_pend = 1;
        end else if (apply) begin
            m_pend = 0;
        end
    endtask

    int cnt_busy, cnt_done, cnt_adc, cnt_p, cnt_shift;

    task automatic clr_counts();
        cnt_busy = 0; cnt_done = 0; cnt_adc = 0; cnt_p = 0; cnt_shift = 0;
    endtask

    task automatic check_outputs();
        logic [3:0] e_ph;
        logic e_adc, e_fd;
        int e_idx, pw, plen, k, c;
        e_ph = 4'b0; e_adc = 0; e_fd = 0; e_idx = 0;
        if (m_run) begin
            pw   = eff(act_pw);
            plen = pw + eff(act_pix) * CPP;
            if (m_off < pw) begin
                e_ph = 4'b1011;                    // {p, l1, l2, r}
            end else if (m_off < plen) begin
                k = m_off - pw; c = k % CPP; e_idx = k / CPP;
                e_ph[3] = 1'b0;
                e_ph[2] = (c < CPP / 2);
                e_ph[1] = (c >= CPP / 2);
                e_ph[0] = (c >= CPP / 2) && (c < 3 * CPP / 4);
                e_adc   = (c == ADC_PH);
                e_fd    = (m_off == plen - 1);
            end
        end
        check("phases", 32'({phi_p, phi_l1, phi_l2, phi_r}), 32'(e_ph));
        check("adc_start", 32'(adc_start), 32'(e_adc));
        check("pixel_idx", 32'(pixel_idx), 32'(e_idx));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("busy", 32'(busy), 32'(m_run));
        check("cfg_pending", 32'(cfg_pending), 32'(m_pend));
        check("l1_l2_overlap", 32'(phi_l1 & phi_l2), 32'd0);
        cnt_busy  += int'(busy);
        cnt_done  += int'(frame_done);
        cnt_adc   += int'(adc_start);
        cnt_p     += int'(phi_p);
        cnt_shift += int'(!phi_p && (phi_l1 || phi_l2));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic load_cfg(input int p, input int w, input int h, input int f);
        cfg_pixels = PIX_W'(p); cfg_pulse_w = PW_W'(w);
        cfg_hold = HOLD_W'(h); cfg_frames = FRAME_W'(f);
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; start = 1'b0; cfg_load = 1'b0;
        cfg_pixels = '0; cfg_pulse_w = '0; cfg_hold = '0; cfg_frames = '0;
        clr_counts();
        run(3);
        rst_n = 1'b1; enable = 1'b1;
        run(2);

        // Two-frame burst with hold.
        load_cfg(4, 4, 10, 2);
        clr_counts();
        pulse_start();
        run(89);
        check("s1_busy_cycles", 32'(cnt_busy), 32'd82);
        check("s1_frame_done", 32'(cnt_done), 32'd2);
        check("s1_adc_pulses", 32'(cnt_adc), 32'd8);
        check("s1_shift_cycles", 32'(cnt_shift), 32'd64);

        // Mid-SHIFT reconfiguration.
        load_cfg(4, 2, 3, 0);
        pulse_start();
        run(12);
        load_cfg(2, 2, 3, 0);
        check("s4_pending", 32'(cfg_pending), 32'd1);
        run(80);
        enable = 1'b0; step(); enable = 1'b1; step();

        // Enable drop mid-HOLD, then a fresh three-frame run.
        load_cfg(2, 2, 20, 3);
        pulse_start();
        run(22);
        enable = 1'b0; step();
        check("s5_idle_busy", 32'(busy), 32'd0);
        enable = 1'b1; step();
        clr_counts();
        pulse_start();
        run(110);
        check("s5_busy_cycles", 32'(cnt_busy), 32'd94);
        check("s5_frame_done", 32'(cnt_done), 32'd3);

        // Continuous, no hold, past frame-counter saturation.
        load_cfg(1, 1, 0, 0);
        clr_counts();
        pulse_start();
        run(2700);
        check("s3_busy_cycles", 32'(cnt_busy), 32'd2701);
        check("s3_frame_done", 32'(cnt_done), 32'd300);
        check("s3_still_busy", 32'(busy), 32'd1);
        enable = 1'b0; step(); enable = 1'b1;

        // Reset mid-PULSE, then zero config.
        load_cfg(4, 4, 10, 2);
        pulse_start();
        run(1);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check("s6_reset_busy", 32'(busy), 32'd0);
        load_cfg(0, 0, 0, 1);
        clr_counts();
        pulse_start();
        run(15);
        check("s6_phi_p_cycles", 32'(cnt_p), 32'd1);
        check("s6_shift_cycles", 32'(cnt_shift), 32'd8);
        check("s6_busy_cycles", 32'(cnt_busy), 32'd9);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(0, 399) != 0);
            enable   = ($urandom_range(0, 49) != 0);
            start    = ($urandom_range(0, 14) == 0);
            cfg_load = ($urandom_range(0, 24) == 0);
            if (cfg_load) begin
                cfg_pixels  = PIX_W'($urandom_range(0, 4));
                cfg_pulse_w = PW_W'($urandom_range(0, 3));
                cfg_hold    = HOLD_W'($urandom_range(0, 5));
                cfg_frames  = FRAME_W'($urandom_range(0, 3));
            end
            step();
        end
        rst_n = 1'b1; enable = 1'b1; start = 1'b0; cfg_load = 1'b0;
        run(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
